// File: rtl/apb_qspi_bridge_pkg.sv
// Shared types, widths and the byte-merge helper for the APB to QSPI register bridge.
package apb_qspi_bridge_pkg;

  localparam int unsigned PERIPH_ADDR_W     = 6;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned STRB_W            = DATA_W / 8;
  localparam int unsigned DEFAULT_LAST_ADDR = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Controller-side register port payload
  typedef struct packed {
    logic                     write;
    logic [STRB_W-1:0]        data_be;
    logic [PERIPH_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]        wdata;
  } ctrl_req_t;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [STRB_W-1:0] strb,
    input logic [DATA_W-1:0] new_word,
    input logic [DATA_W-1:0] old_word
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int unsigned k = 0; k < STRB_W; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_qspi_bridge.sv
// APB slave front-end for the QSPI controller register port, with range/alignment errors.
// Optional read-modify-write of partial-strobe writes: define APB_QSPI_BRIDGE_RMW_EN.
module apb_qspi_bridge
  import apb_qspi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LAST_ADDR = DEFAULT_LAST_ADDR
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [ADDR_W-1:0]        paddr_i,
  input  logic [DATA_W-1:0]        pwdata_i,
  input  logic [STRB_W-1:0]        pstrb_i,
  output logic [DATA_W-1:0]        prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic                     write_o,
  output logic [STRB_W-1:0]        data_be_o,
  output logic [PERIPH_ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0]        wdata_o,
  input  logic [DATA_W-1:0]        rdata_i
);

  localparam int unsigned PA_W = PERIPH_ADDR_W;

  state_e            state_q, state_d;
  logic [PA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef APB_QSPI_BRIDGE_RMW_EN
  logic              rmw_q, rmw_d;
  logic [STRB_W-1:0] strb_q, strb_d;
`endif
  ctrl_req_t         req_q, req_d;
  logic              pready_d, pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              setup;
  logic              addr_err;

  assign setup    = psel_i & ~penable_i;
  assign addr_err = (paddr_i[1:0] != 2'b00)
                  || (paddr_i[ADDR_W-1:PA_W] != '0)
                  || (paddr_i[PA_W-1:0] > PA_W'(LAST_ADDR));

  // Next-state and transfer bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_QSPI_BRIDGE_RMW_EN
    rmw_d   = rmw_q;
    strb_d  = strb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = paddr_i[PA_W-1:0];
          wdata_d = pwdata_i;
          rdata_d = '0;
          err_d   = addr_err;
`ifdef APB_QSPI_BRIDGE_RMW_EN
          rmw_d   = 1'b0;
          strb_d  = pstrb_i;
`endif
          if (addr_err)            state_d = RESP;
          else if (!pwrite_i)      state_d = RD;
          else if (pstrb_i == '1)  state_d = WR;
          else if (pstrb_i == '0)  state_d = RESP;
          else begin
`ifdef APB_QSPI_BRIDGE_RMW_EN
            rmw_d   = 1'b1;
            state_d = RD;
`else
            err_d   = 1'b1;
            state_d = RESP;
`endif
          end
        end
      end
      RD: begin
        if (!psel_i) begin
          state_d = IDLE;
`ifdef APB_QSPI_BRIDGE_RMW_EN
        end else if (rmw_q) begin
          wdata_d = byte_merge(strb_q, wdata_q, rdata_i);
          state_d = WR;
`endif
        end else begin
          rdata_d = rdata_i;
          state_d = RESP;
        end
      end
      WR:      state_d = psel_i ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave straight from flops
    req_d     = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_d)
      RD: begin
        req_d.data_be = '1;
        req_d.addr    = {addr_d[PA_W-1:2], 2'b00};
      end
      WR: begin
        req_d.write   = 1'b1;
        req_d.data_be = '1;
        req_d.addr    = {addr_d[PA_W-1:2], 2'b00};
        req_d.wdata   = wdata_d;
      end
      RESP: begin
        pready_d  = 1'b1;
        pslverr_d = err_d;
        prdata_d  = rdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_QSPI_BRIDGE_RMW_EN
      rmw_q     <= 1'b0;
      strb_q    <= '0;
`endif
      req_q     <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_QSPI_BRIDGE_RMW_EN
      rmw_q     <= rmw_d;
      strb_q    <= strb_d;
`endif
      req_q     <= req_d;
      pready_o  <= pready_d;
      pslverr_o <= pslverr_d;
      prdata_o  <= prdata_d;
    end
  end

  assign write_o   = req_q.write;
  assign data_be_o = req_q.data_be;
  assign addr_o    = req_q.addr;
  assign wdata_o   = req_q.wdata;

endmodule

// File: tb/tb_apb_qspi_bridge.sv
// Directed self-checking bench for apb_qspi_bridge with a word-array controller model.
module tb_apb_qspi_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        wr_stb;
  logic [3:0]  be;
  logic [5:0]  caddr;
  logic [31:0] cwdata, crdata;

  logic [31:0] mem [0:15];
  int          wr_count = 0;

  int          n_pass = 0, n_total = 0;
  logic        obs_we [4];
  logic [3:0]  obs_be [4];
  logic [5:0]  obs_addr [4];
  logic [31:0] obs_wd [4];
  int          lat;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  assign crdata = mem[caddr[5:2]];

  always @(posedge clk) begin
    if (wr_stb === 1'b1) begin
      wr_count++;
      mem[caddr[5:2]] <= cwdata;
    end
  end

  apb_qspi_bridge dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_i  (paddr),
    .pwdata_i (pwdata),
    .pstrb_i  (pstrb),
    .prdata_o (prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .write_o  (wr_stb),
    .data_be_o(be),
    .addr_o   (caddr),
    .wdata_o  (cwdata),
    .rdata_i  (crdata)
  );

  // One APB transfer; lat = access cycles up to and including the pready cycle (0 = timeout)
  task automatic apb_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 0; c < 4; c++) begin
      obs_we[c] = 1'b0; obs_be[c] = '0; obs_addr[c] = '0; obs_wd[c] = '0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        obs_we[c] = wr_stb; obs_be[c] = be; obs_addr[c] = caddr; obs_wd[c] = cwdata;
      end
      if (pready === 1'b1) begin
        lat = c + 1; rd = prdata; er = pslverr;
        break;
      end
    end
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #20;
    n_total++;
    if ({pready, pslverr, wr_stb, be, caddr, prdata, cwdata} !== '0)
      $display("FAIL reset_outputs: got rdy=%b err=%b we=%b be=%h a=%h rd=%h wd=%h want all 0",
               pready, pslverr, wr_stb, be, caddr, prdata, cwdata);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({pready, wr_stb, be} !== '0)
      $display("FAIL idle_after_reset: got rdy=%b we=%b be=%h want 0", pready, wr_stb, be);
    else n_pass++;
  endtask

  task automatic test_read();
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0);
    n_total++; if (obs_be[0] !== 4'hF) $display("FAIL read_be: got %h want f", obs_be[0]); else n_pass++;
    n_total++; if (obs_addr[0] !== 6'h04) $display("FAIL read_addr: got %h want 04", obs_addr[0]); else n_pass++;
    n_total++; if (obs_we[0] !== 1'b0) $display("FAIL read_we: got %b want 0", obs_we[0]); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL read_lat: got %0d want 2", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL read_data: got %h want deadbeef", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL read_err: got %b want 0", er); else n_pass++;
    apb_idle();
  endtask

  task automatic test_write();
    int c0;
    c0 = wr_count;
    apb_xfer(1'b1, 12'h008, 32'h12345678, 4'hF);
    n_total++; if (obs_we[0] !== 1'b1) $display("FAIL wr_we_t1: got %b want 1", obs_we[0]); else n_pass++;
    n_total++; if (obs_wd[0] !== 32'h12345678) $display("FAIL wr_wdata: got %h want 12345678", obs_wd[0]); else n_pass++;
    n_total++; if (obs_addr[0] !== 6'h08) $display("FAIL wr_addr: got %h want 08", obs_addr[0]); else n_pass++;
    n_total++; if (obs_we[1] !== 1'b0) $display("FAIL wr_we_t2: got %b want 0", obs_we[1]); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL wr_lat: got %0d want 2", lat); else n_pass++;
    n_total++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL wr_resp: got err=%b rd=%h want 0/0", er, rd); else n_pass++;
    n_total++; if (wr_count - c0 !== 1) $display("FAIL wr_count: got %0d want 1", wr_count - c0); else n_pass++;
    n_total++; if (mem[2] !== 32'h12345678) $display("FAIL wr_mem: got %h want 12345678", mem[2]); else n_pass++;
    apb_idle();
  endtask

  task automatic test_rmw();
    int c0;
    c0 = wr_count;
    apb_xfer(1'b1, 12'h00C, 32'h0000AA00, 4'b0010);
`ifdef APB_QSPI_BRIDGE_RMW_EN
    n_total++; if (obs_we[0] !== 1'b0 || obs_be[0] !== 4'hF) $display("FAIL rmw_rd: got we=%b be=%h want 0/f", obs_we[0], obs_be[0]); else n_pass++;
    n_total++; if (obs_addr[0] !== 6'h0C) $display("FAIL rmw_rd_addr: got %h want 0c", obs_addr[0]); else n_pass++;
    n_total++; if (obs_we[1] !== 1'b1) $display("FAIL rmw_we: got %b want 1", obs_we[1]); else n_pass++;
    n_total++; if (obs_wd[1] !== 32'h1122AA44) $display("FAIL rmw_wdata: got %h want 1122aa44", obs_wd[1]); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL rmw_lat: got %0d want 3", lat); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL rmw_err: got %b want 0", er); else n_pass++;
    n_total++; if (wr_count - c0 !== 1) $display("FAIL rmw_count: got %0d want 1", wr_count - c0); else n_pass++;
    n_total++; if (mem[3] !== 32'h1122AA44) $display("FAIL rmw_mem: got %h want 1122aa44", mem[3]); else n_pass++;
`else
    n_total++; if (lat !== 1) $display("FAIL partial_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (er !== 1'b1) $display("FAIL partial_err: got %b want 1", er); else n_pass++;
    n_total++; if (obs_we[0] !== 1'b0 || obs_be[0] !== 4'h0) $display("FAIL partial_ctrl: got we=%b be=%h want 0/0", obs_we[0], obs_be[0]); else n_pass++;
    n_total++; if (wr_count - c0 !== 0) $display("FAIL partial_count: got %0d want 0", wr_count - c0); else n_pass++;
    n_total++; if (mem[3] !== 32'h11223344) $display("FAIL partial_mem: got %h want 11223344", mem[3]); else n_pass++;
`endif
    apb_idle();
  endtask

  task automatic test_errors();
    logic [11:0] bad [3];
    int c0;
    bad = '{12'h006, 12'h02C, 12'h100};
    c0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b1, bad[i], 32'hFFFFFFFF, 4'hF);
      n_total++; if (lat !== 1) $display("FAIL err_lat[%0d]: got %0d want 1", i, lat); else n_pass++;
      n_total++; if (er !== 1'b1) $display("FAIL err_flag[%0d]: got %b want 1", i, er); else n_pass++;
      n_total++; if (obs_we[0] !== 1'b0 || obs_be[0] !== 4'h0) $display("FAIL err_ctrl[%0d]: got we=%b be=%h want 0/0", i, obs_we[0], obs_be[0]); else n_pass++;
      apb_idle();
    end
    apb_xfer(1'b0, 12'h02C, 32'h0, 4'h0);
    n_total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) $display("FAIL err_read: got lat=%0d err=%b rd=%h want 1/1/0", lat, er, rd); else n_pass++;
    apb_idle();
    apb_xfer(1'b1, 12'h010, 32'h55555555, 4'h0);
    n_total++; if (lat !== 1 || er !== 1'b0) $display("FAIL zero_strb: got lat=%0d err=%b want 1/0", lat, er); else n_pass++;
    apb_idle();
    n_total++; if (wr_count - c0 !== 0) $display("FAIL err_count: got %0d want 0", wr_count - c0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [31:0] m3;
    c0 = wr_count;
    m3 = mem[3];
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h0000BB00; pstrb = 4'b0010;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({pready, pslverr, wr_stb, be, caddr, prdata, cwdata} !== '0)
      $display("FAIL rst_mid_outputs: got rdy=%b err=%b we=%b be=%h a=%h want all 0", pready, pslverr, wr_stb, be, caddr);
    else n_pass++;
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (wr_count - c0 !== 0) $display("FAIL rst_mid_count: got %0d want 0", wr_count - c0); else n_pass++;
    n_total++; if (mem[3] !== m3) $display("FAIL rst_mid_mem: got %h want %h", mem[3], m3); else n_pass++;
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0);
    n_total++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL rst_mid_read: got lat=%0d rd=%h err=%b want 2/deadbeef/0", lat, rd, er); else n_pass++;
    apb_idle();
  endtask

  task automatic test_back_to_back();
    int c0, lat1;
    logic [31:0] rd1;
    logic er1;
    c0 = wr_count;
    apb_xfer(1'b0, 12'h028, 32'h0, 4'h0);
    lat1 = lat; rd1 = rd; er1 = er;
    apb_xfer(1'b1, 12'h000, 32'hCAFEF00D, 4'hF);
    n_total++; if (lat1 !== 2 || er1 !== 1'b0) $display("FAIL b2b_rd_lat: got lat=%0d err=%b want 2/0", lat1, er1); else n_pass++;
    n_total++; if (rd1 !== 32'h000000A5) $display("FAIL b2b_rd_data: got %h want 000000a5", rd1); else n_pass++;
    n_total++; if (lat !== 2 || er !== 1'b0) $display("FAIL b2b_wr_lat: got lat=%0d err=%b want 2/0", lat, er); else n_pass++;
    apb_idle();
    n_total++; if (wr_count - c0 !== 1) $display("FAIL b2b_count: got %0d want 1", wr_count - c0); else n_pass++;
    n_total++; if (mem[0] !== 32'hCAFEF00D) $display("FAIL b2b_mem: got %h want cafef00d", mem[0]); else n_pass++;
  endtask

  task automatic test_abort();
    int rdy_seen, c0;
    c0 = wr_count;
    rdy_seen = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004; pstrb = 4'h0;
    @(posedge clk); #1;
    psel = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pready === 1'b1) rdy_seen++;
    end
    n_total++; if (rdy_seen !== 0) $display("FAIL abort_ready: got %0d ready cycles want 0", rdy_seen); else n_pass++;
    n_total++; if (be !== 4'h0 || wr_count - c0 !== 0) $display("FAIL abort_ctrl: got be=%h writes=%0d want 0/0", be, wr_count - c0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1]  = 32'hDEADBEEF;
    mem[3]  = 32'h11223344;
    mem[10] = 32'h000000A5;
    test_reset();
    test_read();
    test_write();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/apb_qspi_bridge.md
# apb_qspi_bridge

APB slave front-end for the QSPI controller register file. It converts APB setup/access transfers into the controller's single-cycle register port (`write`/`data_be`/`addr`/`wdata`/`rdata`). It performs read-modify-write for partial PSTRB writes, because the controller writes whole words. It also returns PSLVERR for misaligned or out-of-window accesses. It sits between the APB interconnect and the QSPI register block.

## Interface
- `ADDR_W`, 12: PADDR width.
- `LAST_ADDR`, 40: highest valid byte address in the controller window. Word 0x28 holds the status byte.
- `clk_i`  in  1: single clock; APB and controller sides both run on it.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `psel_i`  in  1: APB select.
- `penable_i`  in  1: APB enable (access phase).
- `pwrite_i`  in  1: 1 = write.
- `paddr_i`  in  ADDR_W: byte address.
- `pwdata_i`  in  32: write data.
- `pstrb_i`  in  4: write byte strobes.
- `prdata_o`  out  32: read data, valid while `pready_o`=1.
- `pready_o`  out  1: transfer complete.
- `pslverr_o`  out  1: error response, valid while `pready_o`=1.
- `write_o`  out  1: controller write strobe, one-cycle pulse.
- `data_be_o`  out  4: controller read byte enables.
- `addr_o`  out  6: controller byte address, always word-aligned.
- `wdata_o`  out  32: controller write data.
- `rdata_i`  in  32: controller read data (combinational from `addr_o`/`data_be_o`).

## Operation
- FSM states:
  - IDLE: waits for a setup cycle.
  - RD: reads the controller.
  - WR: writes the controller.
  - RESP: returns the APB response.
- IDLE, on setup (`psel_i`=1, `penable_i`=0):
  - Capture `paddr_i[5:0]`, `pwrite_i`, `pwdata_i` and `pstrb_i`.
  - Decode the error flag. Error = `paddr_i[1:0]`≠0, OR `paddr_i[ADDR_W-1:6]`≠0, OR `paddr_i[5:0]`>LAST_ADDR.
  - Next state:
    - error → RESP;
    - read → RD;
    - write with `pstrb_i`=4'hF → WR;
    - write with `pstrb_i`=4'h0 → RESP (no controller access, OKAY);
    - other write → RD with RMW flag set.
- RD:
  - Outputs: `addr_o`=captured address, `data_be_o`=4'hF, `write_o`=0.
  - Plain read: latch `rdata_i` into the read-data register, then → RESP.
  - RMW: merged byte k = `pstrb`[k] ? `pwdata` byte k : `rdata_i` byte k; store as write data, then → WR.
- WR:
  - Outputs: `write_o`=1, `addr_o`=captured address, `wdata_o`=write data, `data_be_o`=4'hF.
  - Next: → RESP.
- RESP:
  - Outputs: `pready_o`=1; `prdata_o`=read-data register (0 for writes and errors); `pslverr_o`=error flag.
  - Next: → IDLE.
- In IDLE and RESP: `write_o`=0, `data_be_o`=0, `addr_o`=0, `wdata_o`=0.
- Errored transfers never assert `write_o` or `data_be_o`.
- Master abort (`psel_i`=0 while in RD or WR): next state is IDLE, no WR is issued, no `pready_o`.
- Reset (`rst_ni`=0), at any time including mid-transfer:
  - State → IDLE; all outputs 0 immediately (asynchronous).
  - An RMW write not yet in WR is dropped.

## Timing
- Setup = T0. Access phase starts T1.
- Read: RD in T1, RESP in T2 (one wait state). `prdata_o` is valid in T2.
- Full-strobe write: WR in T1 (controller captures at end of T1), RESP in T2.
- RMW write: RD in T1, WR in T2, RESP in T3 (two wait states).
- Error or zero-strobe write: RESP in T1 (zero wait states).
- Back-to-back transfers: the setup cycle of the next transfer may follow RESP directly; IDLE accepts it in that cycle.
- Every controller-side output is a function of registered state only; there are no combinational paths from APB inputs.

## Configuration
- `APB_QSPI_BRIDGE_RMW_EN`:
  - Defined: partial-strobe writes use the RD→WR RMW path described above.
  - Undefined: partial-strobe writes (`pstrb_i`∉{4'h0, 4'hF}) go straight to RESP with `pslverr_o`=1 and no controller access. The merge logic and RMW flag are not built.

## Structure
- Package `apb_qspi_bridge_pkg` holds:
  - the state enum (IDLE, RD, WR, RESP);
  - `PERIPH_ADDR_W`=6;
  - the default `LAST_ADDR`=40;
  - a `byte_merge(strb, new, old)` function.
- Single module; no sub-module is needed.

## Test plan
- Read 0x04, controller returns 0xDEADBEEF → `data_be_o`=4'hF and `addr_o`=4 in T1; `pready_o`=1, `prdata_o`=0xDEADBEEF, `pslverr_o`=0 in T2.
- Write 0x08 data 0x12345678 with strobe 4'hF → `write_o` pulses exactly once in T1 with `wdata_o`=0x12345678 and `addr_o`=8; `pready_o` in T2.
- RMW: write 0x0C data 0x0000AA00, strobe 4'b0010, controller holds 0x11223344 → WR in T2 carries 0x1122AA44; `pready_o` in T3. With the macro undefined: `pslverr_o`=1 in T1 and no `write_o`.
- Errors: paddr 0x06 (misaligned), 0x2C (>40) and 0x100 (upper bits set) → each gives `pslverr_o`=1 with `pready_o` in T1, `write_o`=0 and `data_be_o`=0.
- Reset during RMW RD (T1) → all outputs 0 immediately; no `write_o` ever issued; the next read after reset completes normally.
- Back-to-back read then write with no idle cycle between them → both complete with correct latencies; `write_o` count = 1.
